// File: rtl/jtframe_ddr_arb_pkg.sv
// Shared definitions for the DDR3 read-port arbiter: FSM encoding, widths and the
// round-robin grant helper.
package jtframe_ddr_arb_pkg;

    localparam int AW     = 29;
    localparam int BW     = 8;
    localparam int TOUT_W = 10;
    localparam logic [7:0] DDR_BE_ALL = 8'hFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DATA  = 2'd2
    } state_t;

    // Index to grant given the pending mask; rr only matters on contention.
    function automatic logic rr_pick(input logic [1:0] pend, input logic rr);
        return (pend == 2'b11) ? rr : pend[1];
    endfunction

endpackage

// File: rtl/jtframe_ddr_arb_slot.sv
// One requester slot: captures address/burst on an accepted read pulse, keeps it
// pending until the burst finishes or times out, and holds the sticky timeout flag.
module jtframe_ddr_arb_slot
    import jtframe_ddr_arb_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          rd,
    input  logic [AW-1:0] req_addr,
    input  logic [BW-1:0] req_burst,
    input  logic          done,
    input  logic          tout,
    output logic          busy,
    output logic          err,
    output logic [AW-1:0] addr,
    output logic [BW-1:0] burst
);

    // done/tout only arrive while busy, so they never collide with a capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy  <= 1'b0;
            err   <= 1'b0;
            addr  <= '0;
            burst <= '0;
        end else if (rd && !busy) begin
            busy  <= 1'b1;
            err   <= 1'b0;
            addr  <= req_addr;
            burst <= (req_burst == '0) ? BW'(1) : req_burst;
        end else if (done) begin
            busy  <= 1'b0;
        end else if (tout) begin
            busy  <= 1'b0;
            err   <= 1'b1;
        end
    end

endmodule

// File: rtl/jtframe_ddr_arb.sv
// Two-requester arbiter for the DDR3 read port: one burst in flight at a time,
// beats routed to the owner. Define JTFRAME_DDR_FIXPRIO_EN for fixed req0 priority.
//
// state | meaning
// IDLE  | no burst in flight; grant a pending slot and load the command
// ISSUE | ddram_rd held until the DDR drops waitrequest
// DATA  | counting beats for the owner; timeout if the DDR goes silent
module jtframe_ddr_arb
    import jtframe_ddr_arb_pkg::*;
#(
    parameter int TOUT = 1023
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    rq_rd,
    input  logic [AW-1:0] rq_addr0,
    input  logic [AW-1:0] rq_addr1,
    input  logic [BW-1:0] rq_burst0,
    input  logic [BW-1:0] rq_burst1,
    output logic [1:0]    rq_busy,
    output logic [1:0]    rq_ready,
    output logic [1:0]    rq_err,
    input  logic          ddram_busy,
    output logic          ddram_rd,
    output logic [AW-1:0] ddram_addr,
    output logic [BW-1:0] ddram_burstcnt,
    output logic [7:0]    ddram_be,
    input  logic          ddram_dout_ready
);

    localparam logic [TOUT_W-1:0] TOUT_LD = TOUT_W'(TOUT - 1);

    state_t              st, st_nx;
    logic                rr, rr_nx;
    logic                g, g_nx, gsel;
    logic [BW-1:0]       beat, beat_nx;
    logic [TOUT_W-1:0]   tcnt, tcnt_nx;
    logic                rd_nx;
    logic [AW-1:0]       addr_nx;
    logic [BW-1:0]       bcnt_nx;
    logic [1:0]          done, tout;
    logic [AW-1:0]       slot_addr0, slot_addr1;
    logic [BW-1:0]       slot_burst0, slot_burst1;

    jtframe_ddr_arb_slot u_slot0 (
        .clk       (clk),
        .rst       (rst),
        .rd        (rq_rd[0]),
        .req_addr  (rq_addr0),
        .req_burst (rq_burst0),
        .done      (done[0]),
        .tout      (tout[0]),
        .busy      (rq_busy[0]),
        .err       (rq_err[0]),
        .addr      (slot_addr0),
        .burst     (slot_burst0)
    );

    jtframe_ddr_arb_slot u_slot1 (
        .clk       (clk),
        .rst       (rst),
        .rd        (rq_rd[1]),
        .req_addr  (rq_addr1),
        .req_burst (rq_burst1),
        .done      (done[1]),
        .tout      (tout[1]),
        .busy      (rq_busy[1]),
        .err       (rq_err[1]),
        .addr      (slot_addr1),
        .burst     (slot_burst1)
    );

    assign ddram_be = DDR_BE_ALL;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st             <= IDLE;
            rr             <= 1'b0;
            g              <= 1'b0;
            beat           <= '0;
            tcnt           <= '0;
            ddram_rd       <= 1'b0;
            ddram_addr     <= '0;
            ddram_burstcnt <= '0;
        end else begin
            st             <= st_nx;
            rr             <= rr_nx;
            g              <= g_nx;
            beat           <= beat_nx;
            tcnt           <= tcnt_nx;
            ddram_rd       <= rd_nx;
            ddram_addr     <= addr_nx;
            ddram_burstcnt <= bcnt_nx;
        end
    end

    always_comb begin
        st_nx    = st;
        rr_nx    = rr;
        g_nx     = g;
        beat_nx  = beat;
        tcnt_nx  = tcnt;
        rd_nx    = ddram_rd;
        addr_nx  = ddram_addr;
        bcnt_nx  = ddram_burstcnt;
        done     = 2'b00;
        tout     = 2'b00;
        rq_ready = 2'b00;
`ifdef JTFRAME_DDR_FIXPRIO_EN
        gsel     = ~rq_busy[0];
`else
        gsel     = rr_pick(rq_busy, rr);
`endif
        case (st)
            IDLE: begin
                if (|rq_busy) begin
                    g_nx    = gsel;
                    addr_nx = gsel ? slot_addr1  : slot_addr0;
                    bcnt_nx = gsel ? slot_burst1 : slot_burst0;
                    rd_nx   = 1'b1;
                    st_nx   = ISSUE;
                end
            end
            ISSUE: begin
                if (!ddram_busy) begin
                    rd_nx   = 1'b0;
                    beat_nx = '0;
                    tcnt_nx = TOUT_LD;
                    st_nx   = DATA;
                end
            end
            DATA: begin
                if (ddram_dout_ready) begin
                    rq_ready[g] = 1'b1;
                    beat_nx     = beat + BW'(1);
                    tcnt_nx     = TOUT_LD;
                    if (beat == ddram_burstcnt - BW'(1)) begin
                        done[g] = 1'b1;
                        rr_nx   = ~g;
                        st_nx   = IDLE;
                    end
                end else if (tcnt == '0) begin
                    tout[g] = 1'b1;
                    rr_nx   = ~g;
                    st_nx   = IDLE;
                end else begin
                    tcnt_nx = tcnt - TOUT_W'(1);
                end
            end
            default: st_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_jtframe_ddr_arb.sv
// Directed bench for jtframe_ddr_arb, built with a 16-cycle data timeout.
module tb_jtframe_ddr_arb;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  rq_rd = 2'b00;
    logic [28:0] rq_addr0 = '0, rq_addr1 = '0;
    logic [7:0]  rq_burst0 = '0, rq_burst1 = '0;
    logic [1:0]  rq_busy, rq_ready, rq_err;
    logic        ddram_busy = 1'b0;
    logic        ddram_rd;
    logic [28:0] ddram_addr;
    logic [7:0]  ddram_burstcnt;
    logic [7:0]  ddram_be;
    logic        ddram_dout_ready = 1'b0;

    int vec = 0;
    int errs = 0;

    jtframe_ddr_arb #(.TOUT(16)) dut (
        .clk              (clk),
        .rst              (rst),
        .rq_rd            (rq_rd),
        .rq_addr0         (rq_addr0),
        .rq_addr1         (rq_addr1),
        .rq_burst0        (rq_burst0),
        .rq_burst1        (rq_burst1),
        .rq_busy          (rq_busy),
        .rq_ready         (rq_ready),
        .rq_err           (rq_err),
        .ddram_busy       (ddram_busy),
        .ddram_rd         (ddram_rd),
        .ddram_addr       (ddram_addr),
        .ddram_burstcnt   (ddram_burstcnt),
        .ddram_be         (ddram_be),
        .ddram_dout_ready (ddram_dout_ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        tick();
    endtask

    task automatic pulse(input logic [1:0] which);
        rq_rd = which;
        tick();
        rq_rd = 2'b00;
    endtask

    task automatic wait_rd(input string name);
        int n;
        n = 0;
        while (ddram_rd !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        vec++;
        if (ddram_rd !== 1'b1) begin
            errs++;
            $display("FAIL %s: ddram_rd got %b want 1 within 50 cycles", name, ddram_rd);
        end
    endtask

    task automatic deliver(input int n, input int idx, output int got, output int other);
        got = 0;
        other = 0;
        for (int i = 0; i < n; i++) begin
            ddram_dout_ready = 1'b1;
            #2;
            if (rq_ready[idx] === 1'b1) got++;
            if (rq_ready[1-idx] === 1'b1) other++;
            tick();
        end
        ddram_dout_ready = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        vec++;
        if ({rq_busy, rq_ready, rq_err, ddram_rd} !== 7'd0 || ddram_addr !== '0 || ddram_burstcnt !== '0) begin
            errs++;
            $display("FAIL reset_outputs: busy=%b ready=%b err=%b rd=%b addr=%h bcnt=%0d want all 0",
                     rq_busy, rq_ready, rq_err, ddram_rd, ddram_addr, ddram_burstcnt);
        end
        vec++;
        if (ddram_be !== 8'hFF) begin
            errs++;
            $display("FAIL reset_be: got %h want ff", ddram_be);
        end
        do_reset();
    endtask

    task automatic test_single();
        int got, other;
        rq_addr0 = 29'h3000000;
        rq_burst0 = 8'd128;
        pulse(2'b01);
        vec++;
        if (rq_busy !== 2'b01 || ddram_rd !== 1'b0) begin
            errs++;
            $display("FAIL single_capture: busy=%b rd=%b want busy=01 rd=0", rq_busy, ddram_rd);
        end
        tick();
        vec++;
        if (ddram_rd !== 1'b1 || ddram_addr !== 29'h3000000 || ddram_burstcnt !== 8'd128) begin
            errs++;
            $display("FAIL single_issue: rd=%b addr=%h bcnt=%0d want 1 3000000 128", ddram_rd, ddram_addr, ddram_burstcnt);
        end
        tick();
        vec++;
        if (ddram_rd !== 1'b0) begin
            errs++;
            $display("FAIL single_rd_width: rd=%b want 0 after one cycle", ddram_rd);
        end
        deliver(128, 0, got, other);
        vec++;
        if (got != 128 || other != 0) begin
            errs++;
            $display("FAIL single_beats: ready0=%0d ready1=%0d want 128 0", got, other);
        end
        vec++;
        if (rq_busy !== 2'b00) begin
            errs++;
            $display("FAIL single_busy_clear: busy=%b want 00", rq_busy);
        end
    endtask

    task automatic test_round_robin();
        int got, other;
        do_reset();
        rq_addr0 = 29'h100;
        rq_addr1 = 29'h200;
        rq_burst0 = 8'd4;
        rq_burst1 = 8'd4;
        pulse(2'b11);
        wait_rd("rr_first");
        vec++;
        if (ddram_addr !== 29'h100) begin
            errs++;
            $display("FAIL rr_first_grant: addr=%h want 100", ddram_addr);
        end
        tick();
        deliver(4, 0, got, other);
        vec++;
        if (got != 4 || other != 0 || rq_busy !== 2'b10) begin
            errs++;
            $display("FAIL rr_first_beats: ready0=%0d ready1=%0d busy=%b want 4 0 10", got, other, rq_busy);
        end
        tick();
        vec++;
        if (ddram_rd !== 1'b1 || ddram_addr !== 29'h200) begin
            errs++;
            $display("FAIL rr_back_to_back: rd=%b addr=%h want 1 200", ddram_rd, ddram_addr);
        end
        tick();
        deliver(4, 1, got, other);
        vec++;
        if (got != 4 || other != 0 || rq_busy !== 2'b00) begin
            errs++;
            $display("FAIL rr_second_beats: ready1=%0d ready0=%0d busy=%b want 4 0 00", got, other, rq_busy);
        end
        pulse(2'b11);
        wait_rd("rr_third");
        vec++;
        if (ddram_addr !== 29'h100) begin
            errs++;
            $display("FAIL rr_third_grant: addr=%h want 100", ddram_addr);
        end
        tick();
        deliver(4, 0, got, other);
        tick();
        tick();
        deliver(4, 1, got, other);
    endtask

    // rr points at req1 when both arrive together: round-robin serves req1, fixed priority req0.
    task automatic test_priority();
        int got, other;
        logic [28:0] want_first, want_second;
        int first_idx;
`ifdef JTFRAME_DDR_FIXPRIO_EN
        want_first = 29'h20; want_second = 29'h30; first_idx = 0;
`else
        want_first = 29'h30; want_second = 29'h20; first_idx = 1;
`endif
        do_reset();
        rq_addr0 = 29'h10;
        rq_burst0 = 8'd1;
        pulse(2'b01);
        wait_rd("prio_warm");
        tick();
        deliver(1, 0, got, other);
        rq_addr0 = 29'h20;
        rq_addr1 = 29'h30;
        rq_burst1 = 8'd1;
        pulse(2'b11);
        wait_rd("prio_first");
        vec++;
        if (ddram_addr !== want_first) begin
            errs++;
            $display("FAIL prio_first_grant: addr=%h want %h", ddram_addr, want_first);
        end
        tick();
        deliver(1, first_idx, got, other);
        vec++;
        if (got != 1 || other != 0) begin
            errs++;
            $display("FAIL prio_first_beat: owner=%0d other=%0d want 1 0", got, other);
        end
        tick();
        vec++;
        if (ddram_rd !== 1'b1 || ddram_addr !== want_second) begin
            errs++;
            $display("FAIL prio_second_grant: rd=%b addr=%h want 1 %h", ddram_rd, ddram_addr, want_second);
        end
        tick();
        deliver(1, 1 - first_idx, got, other);
    endtask

    task automatic test_wait_request();
        int got, other, stable;
        do_reset();
        ddram_busy = 1'b1;
        rq_addr0 = 29'h55;
        rq_burst0 = 8'd3;
        pulse(2'b01);
        wait_rd("wreq_issue");
        stable = 0;
        for (int i = 0; i <= 20; i++) begin
            if (ddram_rd === 1'b1 && ddram_addr === 29'h55 && ddram_burstcnt === 8'd3) stable++;
            if (i == 20) ddram_busy = 1'b0;
            tick();
        end
        vec++;
        if (stable != 21 || ddram_rd !== 1'b0) begin
            errs++;
            $display("FAIL wreq_hold: stable=%0d rd=%b want 21 0", stable, ddram_rd);
        end
        deliver(3, 0, got, other);
        vec++;
        if (got != 3 || rq_busy !== 2'b00) begin
            errs++;
            $display("FAIL wreq_beats: ready0=%0d busy=%b want 3 00", got, rq_busy);
        end
    endtask

    task automatic test_timeout();
        int got, other, early;
        do_reset();
        rq_addr1 = 29'h77;
        rq_burst1 = 8'd8;
        pulse(2'b10);
        wait_rd("tout_issue");
        tick();
        deliver(2, 1, got, other);
        early = 0;
        for (int i = 1; i <= 15; i++) begin
            tick();
            if (rq_err !== 2'b00) early++;
        end
        vec++;
        if (early != 0) begin
            errs++;
            $display("FAIL tout_early: err seen on %0d of 15 cycles want 0", early);
        end
        tick();
        vec++;
        if (rq_err !== 2'b10 || rq_busy !== 2'b00) begin
            errs++;
            $display("FAIL tout_flag: err=%b busy=%b want 10 00", rq_err, rq_busy);
        end
        deliver(3, 1, got, other);
        vec++;
        if (got != 0 || other != 0 || ddram_rd !== 1'b0) begin
            errs++;
            $display("FAIL tout_late_beats: ready1=%0d ready0=%0d rd=%b want 0 0 0", got, other, ddram_rd);
        end
        rq_burst1 = 8'd1;
        pulse(2'b10);
        vec++;
        if (rq_err !== 2'b00 || rq_busy !== 2'b10) begin
            errs++;
            $display("FAIL tout_err_clear: err=%b busy=%b want 00 10", rq_err, rq_busy);
        end
        wait_rd("tout_retry");
        tick();
        deliver(1, 1, got, other);
    endtask

    task automatic test_reset_mid_burst();
        int got, other, stray;
        do_reset();
        rq_addr0 = 29'h400;
        rq_burst0 = 8'd8;
        pulse(2'b01);
        wait_rd("rst_issue");
        tick();
        deliver(3, 0, got, other);
        ddram_dout_ready = 1'b1;
        #1;
        rst = 1'b1;
        #1;
        vec++;
        if ({rq_busy, rq_ready, rq_err, ddram_rd} !== 7'd0 || ddram_addr !== '0 || ddram_burstcnt !== '0) begin
            errs++;
            $display("FAIL rst_mid_outputs: busy=%b ready=%b err=%b rd=%b addr=%h bcnt=%0d want all 0",
                     rq_busy, rq_ready, rq_err, ddram_rd, ddram_addr, ddram_burstcnt);
        end
        tick();
        rst = 1'b0;
        stray = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (rq_ready !== 2'b00) stray++;
        end
        ddram_dout_ready = 1'b0;
        vec++;
        if (stray != 0) begin
            errs++;
            $display("FAIL rst_stray_beats: ready seen %0d times want 0", stray);
        end
        rq_addr1 = 29'h9;
        rq_burst1 = 8'd0;
        pulse(2'b10);
        wait_rd("rst_zero_burst");
        vec++;
        if (ddram_burstcnt !== 8'd1 || ddram_addr !== 29'h9) begin
            errs++;
            $display("FAIL zero_burst_cmd: bcnt=%0d addr=%h want 1 9", ddram_burstcnt, ddram_addr);
        end
        tick();
        deliver(3, 1, got, other);
        vec++;
        if (got != 1 || other != 0 || rq_busy !== 2'b00) begin
            errs++;
            $display("FAIL zero_burst_beats: ready1=%0d ready0=%0d busy=%b want 1 0 00", got, other, rq_busy);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_priority();
        test_wait_request();
        test_timeout();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
